upf_power_sequencer: RTL

Power-gating sequencer that drives the clock-enable, isolation, retention (RET) and power-switch (PWR) controls of one switchable domain. It is the initiator side of the retention-register protocol: a posedge of RET while PWR=1 stores, and a negedge of RET while PWR=1 restores. It sits in the always-on domain beside the ALU and is controlled by a level request / pulse acknowledge handshake.

---
 rtl/upf_power_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/upf_power_sequencer.sv
// Power-gating sequencer for one switchable domain: drives clk_en, iso, ret and pwr in a fixed order.
// Optional retention save/restore steps are built only when UPF_SEQ_RETENTION_EN is defined.
module upf_power_sequencer #(
  parameter int STEP_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pd_req,
  input  logic       pu_req,
  output logic       ack,
  output logic       busy,
  output logic       clk_en,
  output logic       iso,
  output logic       ret,
  output logic       pwr,
  output logic [3:0] state
);

  localparam logic [3:0] ST_ON      = 4'd0;
  localparam logic [3:0] ST_CLK_OFF = 4'd1;
  localparam logic [3:0] ST_ISO_ON  = 4'd2;
  localparam logic [3:0] ST_SAVE    = 4'd3;
  localparam logic [3:0] ST_PWR_OFF = 4'd4;
  localparam logic [3:0] ST_OFF     = 4'd5;
  localparam logic [3:0] ST_PWR_ON  = 4'd6;
  localparam logic [3:0] ST_RESTORE = 4'd7;
  localparam logic [3:0] ST_ISO_OFF = 4'd8;
  localparam logic [3:0] ST_CLK_ON  = 4'd9;

`ifdef UPF_SEQ_RETENTION_EN
  localparam logic RET_EN = 1'b1;
`else
  localparam logic RET_EN = 1'b0;
`endif

  localparam logic [7:0] STEP_DW   = 8'(STEP_CYCLES);
  localparam logic [7:0] SETTLE_DW = 8'(SETTLE_CYCLES);

  logic [7:0] cnt;
  logic [3:0] next_state;
  logic [3:0] ctl_next;
  logic       dwell_done;
  logic       next_rest;

  // Control vector {clk_en, iso, ret, pwr} held in each state; ret is masked when retention is absent.
  function automatic logic [3:0] controls_for(input logic [3:0] s);
    logic [3:0] c;
    case (s)
      ST_ON:      c = 4'b1001;
      ST_CLK_OFF: c = 4'b0001;
      ST_ISO_ON:  c = 4'b0101;
      ST_SAVE:    c = 4'b0111;
      ST_PWR_OFF: c = 4'b0110;
      ST_OFF:     c = 4'b0110;
      ST_PWR_ON:  c = 4'b0111;
      ST_RESTORE: c = 4'b0101;
      ST_ISO_OFF: c = 4'b0001;
      ST_CLK_ON:  c = 4'b1001;
      default:    c = 4'b1001;
    endcase
    c[1] = c[1] & RET_EN;
    return c;
  endfunction

  always_comb begin
    next_state = state;
    dwell_done = (cnt == ((state == ST_PWR_ON) ? SETTLE_DW : STEP_DW));
    case (state)
      ST_ON:      if (pd_req) next_state = ST_CLK_OFF;
      ST_OFF:     if (pu_req) next_state = ST_PWR_ON;
      ST_CLK_OFF: if (dwell_done) next_state = ST_ISO_ON;
      ST_ISO_ON:  if (dwell_done) next_state = RET_EN ? ST_SAVE : ST_PWR_OFF;
      ST_SAVE:    if (dwell_done) next_state = ST_PWR_OFF;
      ST_PWR_OFF: if (dwell_done) next_state = ST_OFF;
      ST_PWR_ON:  if (dwell_done) next_state = RET_EN ? ST_RESTORE : ST_ISO_OFF;
      ST_RESTORE: if (dwell_done) next_state = ST_ISO_OFF;
      ST_ISO_OFF: if (dwell_done) next_state = ST_CLK_ON;
      ST_CLK_ON:  if (dwell_done) next_state = ST_ON;
      default:    next_state = ST_ON;
    endcase
    next_rest = (next_state == ST_ON) || (next_state == ST_OFF);
    ctl_next  = controls_for(next_state);
  end

  // Outputs are decoded from the next state so they change exactly on state entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_ON;
      cnt    <= 8'd0;
      clk_en <= 1'b1;
      iso    <= 1'b0;
      ret    <= 1'b0;
      pwr    <= 1'b1;
      ack    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state <= next_state;
      if (next_rest)
        cnt <= 8'd0;
      else if (next_state != state)
        cnt <= 8'd1;
      else
        cnt <= cnt + 8'd1;
      {clk_en, iso, ret, pwr} <= ctl_next;
      ack  <= ((state == ST_CLK_ON) && (next_state == ST_ON)) ||
              ((state == ST_PWR_OFF) && (next_state == ST_OFF));
      busy <= !next_rest;
    end
  end

endmodule
